// File: rtl/mvb_fifox_multi_pkg.sv
// Shared widths, item/pointer typedefs and mask arithmetic helpers for the multi-item MVB FIFO.
package mvb_fifox_multi_pkg;

  localparam int MAX_MVB_ITEMS  = 32;
  localparam int DEF_MVB_ITEMS  = 4;
  localparam int DEF_ITEM_WIDTH = 32;
  localparam int DEF_ITEMS      = 64;

  typedef logic [DEF_ITEM_WIDTH-1:0]   item_t;
  typedef logic [$clog2(DEF_ITEMS)-1:0] ptr_t;
  typedef logic [$clog2(DEF_ITEMS):0]   cnt_t;

  function automatic int ptr_width(input int items);
    return $clog2(items);
  endfunction

  // One extra bit so a completely full FIFO is distinguishable from empty.
  function automatic int cnt_width(input int items);
    return $clog2(items) + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic int popcount(input logic [MAX_MVB_ITEMS-1:0] mask);
    int s;
    s = 0;
    for (int j = 0; j < MAX_MVB_ITEMS; j++) s += int'(mask[j]);
    return s;
  endfunction

  // Number of set bits strictly below position idx.
  function automatic int prefix_sum(input logic [MAX_MVB_ITEMS-1:0] mask, input int idx);
    int s;
    s = 0;
    for (int j = 0; j < MAX_MVB_ITEMS; j++) begin
      if (j < idx) s += int'(mask[j]);
    end
    return s;
  endfunction

endpackage

// File: rtl/mvb_fifox_multi_if.sv
// MVB word bundle: items, per-item valids and the word-level src/dst ready handshake.
interface mvb_fifox_multi_if #(
  parameter int MVB_ITEMS  = 4,
  parameter int ITEM_WIDTH = 32
);
  logic [MVB_ITEMS*ITEM_WIDTH-1:0] DATA;
  logic [MVB_ITEMS-1:0]            VLD;
  logic                            SRC_RDY;
  logic                            DST_RDY;

  modport master (output DATA, VLD, SRC_RDY, input DST_RDY);
  modport slave  (input DATA, VLD, SRC_RDY, output DST_RDY);
endinterface

// File: rtl/mvb_fifox_multi_compact.sv
// Maps masked items starting at a circular address onto banks: per bank the enable, source item and row.
// Purely combinational; used for compacting RX writes and, with a full mask, realigning TX reads.
module mvb_fifox_multi_compact
  import mvb_fifox_multi_pkg::*;
#(
  parameter int MVB_ITEMS = 4,
  parameter int ITEMS     = 64
) (
  input  logic [MVB_ITEMS-1:0]                                  i_vld,
  input  logic [ptr_width(ITEMS)-1:0]                           i_ptr,
  output logic [MVB_ITEMS-1:0]                                  o_en,
  output logic [MVB_ITEMS-1:0][idx_width(MVB_ITEMS)-1:0]        o_sel,
  output logic [MVB_ITEMS-1:0][$clog2(ITEMS/MVB_ITEMS)-1:0]     o_row
);
  localparam int PW = ptr_width(ITEMS);
  localparam int SW = idx_width(MVB_ITEMS);
  localparam int RW = $clog2(ITEMS/MVB_ITEMS);

  logic [MVB_ITEMS-1:0][PW-1:0] w_addr;

  always_comb begin
    for (int i = 0; i < MVB_ITEMS; i++) begin
      w_addr[i] = i_ptr + PW'(prefix_sum(MAX_MVB_ITEMS'(i_vld), i));
    end
  end

  // Consecutive addresses fall in distinct banks, so each bank gets at most one item.
  always_comb begin
    o_en  = '0;
    o_sel = '0;
    o_row = '0;
    for (int i = 0; i < MVB_ITEMS; i++) begin
      if (i_vld[i]) begin
        o_en [int'(w_addr[i] % PW'(MVB_ITEMS))] = 1'b1;
        o_sel[int'(w_addr[i] % PW'(MVB_ITEMS))] = SW'(i);
        o_row[int'(w_addr[i] % PW'(MVB_ITEMS))] = RW'(w_addr[i] / PW'(MVB_ITEMS));
      end
    end
  end

endmodule

// File: rtl/mvb_fifox_multi.sv
// Multi-item MVB FIFO: compacts sparse RX words into banked storage, presents up to MVB_ITEMS oldest
// items fall-through on TX (1-cycle write-to-read latency); RX_DST_RDY is registered and needs a full word of space.
module mvb_fifox_multi
  import mvb_fifox_multi_pkg::*;
#(
  parameter int MVB_ITEMS           = 4,
  parameter int ITEM_WIDTH          = 32,
  parameter int ITEMS               = 64,
  parameter int ALMOST_FULL_OFFSET  = 8,
  parameter int ALMOST_EMPTY_OFFSET = 8
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  mvb_fifox_multi_if.slave             RX,
  mvb_fifox_multi_if.master            TX,
  output logic [cnt_width(ITEMS)-1:0]  STATUS,
  output logic                         AFULL,
  output logic                         AEMPTY
);
  localparam int PW    = ptr_width(ITEMS);
  localparam int CW    = cnt_width(ITEMS);
  localparam int SW    = idx_width(MVB_ITEMS);
  localparam int DEPTH = ITEMS / MVB_ITEMS;
  localparam int RW    = $clog2(DEPTH);

  if (!is_pow2(MVB_ITEMS) || MVB_ITEMS > MAX_MVB_ITEMS || !is_pow2(ITEMS) ||
      (ITEMS % MVB_ITEMS) != 0 || ITEMS < 2*MVB_ITEMS ||
      ALMOST_FULL_OFFSET > ITEMS || ALMOST_EMPTY_OFFSET > ITEMS) begin : g_param_err
    $error("mvb_fifox_multi: illegal parameter combination");
  end

  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_dst_rdy;
  logic [ITEM_WIDTH-1:0] r_mem [MVB_ITEMS][DEPTH];

  logic                          w_wr, w_rd, w_src_rdy;
  logic [CW-1:0]                 w_k, w_m, w_m_rd, w_cnt_nxt;
  logic [MVB_ITEMS-1:0]          w_wr_vld, w_wr_en, w_rd_en;
  logic [MVB_ITEMS-1:0][SW-1:0]  w_wr_sel, w_rd_sel;
  logic [MVB_ITEMS-1:0][RW-1:0]  w_wr_row, w_rd_row;

  assign w_wr      = RX.SRC_RDY & r_dst_rdy;
  assign w_wr_vld  = RX.VLD & {MVB_ITEMS{w_wr}};
  assign w_k       = CW'(popcount(MAX_MVB_ITEMS'(w_wr_vld)));
  assign w_src_rdy = (r_cnt != '0);
  assign w_m       = (r_cnt >= CW'(MVB_ITEMS)) ? CW'(MVB_ITEMS) : r_cnt;
  assign w_rd      = w_src_rdy & TX.DST_RDY;
  assign w_m_rd    = w_rd ? w_m : '0;
  assign w_cnt_nxt = r_cnt + w_k - w_m_rd;

  mvb_fifox_multi_compact #(.MVB_ITEMS(MVB_ITEMS), .ITEMS(ITEMS)) u_wr_map (
    .i_vld (w_wr_vld),
    .i_ptr (r_wr_ptr),
    .o_en  (w_wr_en),
    .o_sel (w_wr_sel),
    .o_row (w_wr_row)
  );

  // Full mask from rd_ptr: o_sel then names the TX slot each bank's output belongs to.
  mvb_fifox_multi_compact #(.MVB_ITEMS(MVB_ITEMS), .ITEMS(ITEMS)) u_rd_map (
    .i_vld ({MVB_ITEMS{1'b1}}),
    .i_ptr (r_rd_ptr),
    .o_en  (w_rd_en),
    .o_sel (w_rd_sel),
    .o_row (w_rd_row)
  );

  always_ff @(posedge CLK) begin
    for (int b = 0; b < MVB_ITEMS; b++) begin
      if (w_wr_en[b]) r_mem[b][w_wr_row[b]] <= RX.DATA[int'(w_wr_sel[b])*ITEM_WIDTH +: ITEM_WIDTH];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_dst_rdy <= 1'b0;
    end else begin
      r_wr_ptr  <= r_wr_ptr + PW'(w_k);
      r_rd_ptr  <= r_rd_ptr + PW'(w_m_rd);
      r_cnt     <= w_cnt_nxt;
      r_dst_rdy <= (CW'(ITEMS) - w_cnt_nxt) >= CW'(MVB_ITEMS);
    end
  end

  always_comb begin
    TX.DATA = '0;
    TX.VLD  = '0;
    for (int b = 0; b < MVB_ITEMS; b++) begin
      if (w_rd_en[b]) TX.DATA[int'(w_rd_sel[b])*ITEM_WIDTH +: ITEM_WIDTH] = r_mem[b][w_rd_row[b]];
    end
    for (int i = 0; i < MVB_ITEMS; i++) TX.VLD[i] = (CW'(i) < w_m);
  end

  assign TX.SRC_RDY = w_src_rdy;
  assign RX.DST_RDY = r_dst_rdy;
  assign STATUS     = r_cnt;
  assign AFULL      = (r_cnt >= CW'(ITEMS - ALMOST_FULL_OFFSET));
  assign AEMPTY     = (r_cnt <= CW'(ALMOST_EMPTY_OFFSET));

  always @(posedge CLK) begin
    if (RESET_N) begin
      assert (r_cnt <= CW'(ITEMS));
      assert (r_dst_rdy || (w_wr_en == '0));
    end
  end

endmodule

// File: doc/mvb_fifox_multi.md
Name: mvb_fifox_multi

Overview:
- Multi-item FIFO for MVB streams, successor to the single-item FIFOX.
- Accepts up to MVB_ITEMS items per cycle with arbitrary valid masks. Valid items are compacted in index order and stored in a circular buffer.
- Presents up to MVB_ITEMS oldest items per cycle on the TX side, in fall-through mode.
- Sits between MVB producers and consumers whose per-cycle item counts differ. Exports fill-level status and almost-full/almost-empty flags.

Parameters:
- MVB_ITEMS, 4, items per MVB word on RX and TX; power of 2, ≥1.
- ITEM_WIDTH, 32, bits per item.
- ITEMS, 64, capacity in items; power of 2, multiple of MVB_ITEMS, ≥2*MVB_ITEMS.
- ALMOST_FULL_OFFSET, 8, AFULL asserts when count ≥ ITEMS-ALMOST_FULL_OFFSET.
- ALMOST_EMPTY_OFFSET, 8, AEMPTY asserts when count ≤ ALMOST_EMPTY_OFFSET.

Ports:
- CLK  in  1  clock.
- RESET_N  in  1  reset; asynchronous, active-low.
- RX_DATA  in  MVB_ITEMS*ITEM_WIDTH  input items; item i occupies bits [i*ITEM_WIDTH +: ITEM_WIDTH].
- RX_VLD  in  MVB_ITEMS  per-item valid.
- RX_SRC_RDY  in  1  word valid.
- RX_DST_RDY  out  1  FIFO can accept a full word.
- TX_DATA  out  MVB_ITEMS*ITEM_WIDTH  output items; item 0 is the oldest.
- TX_VLD  out  MVB_ITEMS  per-item valid.
- TX_SRC_RDY  out  1  at least one item present.
- TX_DST_RDY  in  1  consumer takes all presented items.
- STATUS  out  log2(ITEMS)+1  current item count.
- AFULL  out  1  almost full.
- AEMPTY  out  1  almost empty.

Behaviour:
- State: wr_ptr and rd_ptr, each log2(ITEMS) bits, wrapping naturally modulo ITEMS; registered count, log2(ITEMS)+1 bits.
- Reset (RESET_N=0, async): pointers=0, count=0, RX_DST_RDY=0, TX_SRC_RDY=0, TX_VLD=0, STATUS=0, AFULL=0, AEMPTY=1. TX_DATA content is don't-care.
- First cycle after reset release: RX_DST_RDY=1.
- RX_DST_RDY is registered: 1 iff next-cycle free space (ITEMS-count) ≥ MVB_ITEMS. It never depends combinationally on RX inputs.
- Write event: RX_SRC_RDY & RX_DST_RDY.
  - Let k = popcount(RX_VLD). The j-th set item (ascending index) is written to address wr_ptr+j.
  - wr_ptr advances by k.
  - k=0 is a legal no-op.
- Storage: MVB_ITEMS banks, each ITEMS/MVB_ITEMS deep. Address a maps to bank a mod MVB_ITEMS, row a / MVB_ITEMS. Each bank takes at most one write and one read per cycle; asynchronous read.
- TX view:
  - m = min(count, MVB_ITEMS).
  - TX item i = storage[rd_ptr+i] for i<m.
  - TX_VLD[i] = (i<m).
  - TX_SRC_RDY = (count>0).
- Read event: TX_SRC_RDY & TX_DST_RDY. All m presented items are consumed; rd_ptr += m.
- Latency: an item written in cycle t is visible on TX in cycle t+1 at the earliest.
- Simultaneous read and write: count_next = count + k - m_read. Both pointers update in the same cycle.
- Full boundary: when free < MVB_ITEMS, RX_DST_RDY=0 even if free > 0. The FIFO never overflows.
- Empty boundary: count=0 gives TX_SRC_RDY=0 and TX_VLD=0; TX_DST_RDY is ignored.
- STATUS=count, updated one cycle after the event.
- AFULL and AEMPTY are combinational from registered count.
- Reset mid-operation discards all contents immediately; no partial words survive.
- Assertions:
  - count ≤ ITEMS.
  - No write when RX_DST_RDY=0.
  - Elaboration check on parameter constraints.

Decomposition:
- Package mvb_fifox_multi_pkg holds:
  - helper functions: clog2-based widths, popcount, prefix-sum of a valid mask.
  - typedef item_t (logic [ITEM_WIDTH-1:0]).
  - typedefs for pointer and count widths.
- Sub-module mvb_fifox_multi_compact: combinational prefix-sum crossbar mapping RX items to bank-rotated write slots (bank index, row, enable per bank). The same rotation logic is reused, mirrored, to realign read banks so the oldest item lands at TX item 0.

Test Plan:
- Reset release, no traffic → cycle 1 after release: RX_DST_RDY=1, STATUS=0, AEMPTY=1, AFULL=0, TX_SRC_RDY=0.
- Sparse write RX_VLD=4'b1010, items A0..A3, TX_DST_RDY=0 → next cycle: TX_VLD=4'b0011, TX item0=A1, item1=A3, STATUS=2.
- Fill with 16 full writes (64 items), TX_DST_RDY=0 → RX_DST_RDY drops once STATUS=64-4+1 would be impossible, i.e. when free<4, so after the 15th write STATUS=60 and RX_DST_RDY=1, after the 16th STATUS=64 and RX_DST_RDY=0. AFULL=1 from STATUS≥56.
- Wrap-around: 200 cycles of random RX_VLD masks with random TX_DST_RDY → scoreboard order matches exactly; pointers wrap past 63 without loss.
- Simultaneous: count=3, write 4 items and read 3 in the same cycle → STATUS=4 next cycle; TX item0 = first new item.
- Async reset asserted mid-stream with STATUS=37 → outputs at reset values within the same cycle; after release STATUS=0 and no stale TX_VLD.
